fnd_time_display: RTL and testbench
===================================

// Module: fnd_time_display
// PURPOSE
//  Display-side consumer of the stopwatch/watch time buses (msec/sec/min/hour).
//  Samples the time fields once per scan frame and splits them into decimal digits.
//  Time-multiplexes four common-anode 7-segment digits (active-low COM and segments).
//  Blinks the centre decimal point at 1 Hz from msec. Sits between the stopwatch datapath and board pins.
// PARAMETERS
//  SCAN_COUNT  100_000  clk cycles each digit is driven (1 kHz digit rate @100 MHz); sim uses 4
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous, active-high reset
//  msec      in   7  centiseconds, 0..99
//  sec       in   6  seconds, 0..59
//  min       in   6  minutes, 0..59
//  hour      in   5  hours, 0..23
//  sw_mode   in   1  0: show sec.msec (SS.cc); 1: show hour.min (HH.MM)
//  fnd_com   out  4  digit enables, active-low; bit0 = rightmost digit
//  fnd_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high; all registers update on posedge clk only.
//  - Reset (rst=1 at an edge): scan_cnt=0, dig_idx=0, snapshot regs=0, snap_mode=0, fnd_com=4'b1111, fnd_data=8'hFF.
//  - Scan counter: 0..SCAN_COUNT-1, wraps to 0; scan_tick when scan_cnt==SCAN_COUNT-1.
//  - On scan_tick, dig_idx (2 bit) advances 0->1->2->3->0. Each digit is held for exactly SCAN_COUNT cycles.
//  - Snapshot: on the edge where dig_idx goes 3->0, latch msec/sec/min/hour/sw_mode.
//    A frame always shows one coherent sample. Input or mode changes mid-frame are not visible until the next frame.
//  - Field select (from snapshot): mode0 lo=msec, hi=sec; mode1 lo=min, hi=hour.
//  - Digit values: d0=lo%10, d1=lo/10, d2=hi%10, d3=hi/10. Use a 7-bit unsigned divide-by-10 (constant, combinational).
//  - Segment decode, active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//    Any digit value >9 decodes to blank (segments 7'h7F). Out-of-range inputs are never clamped.
//  - DP: lit (bit7=0) only on dig_idx==2, and only when snapshot msec<50 (1 Hz blink, both modes). Off on all other digits.
//  - fnd_com = ~(4'b0001<<dig_idx). Exactly one digit is active at any time after reset.
//  - Outputs are registered. They reflect dig_idx/snapshot with 1-cycle latency.
//    First cycle after reset release: fnd_com=1110, fnd_data=C0.
//  - Reset mid-frame: outputs go blank on that edge. The frame restarts at digit 0 with a zero snapshot.
//  - Ghosting rule: fnd_com and fnd_data change on the same edge; no cycle with new COM and old data.
// STRUCTURE
//  - Shared include fnd_defs.vh holds the SEG_0..SEG_9 and SEG_BLANK codes, DP_ON_MASK (8'h7F), NUM_DIGITS=4, and the mode encodings.
//  - Sub-module fnd_seg_decoder: pure combinational, 4-bit digit + dp -> 8-bit active-low pattern.
//  - Top holds the scan counter, dig_idx, the snapshot registers, digit split/mux and the output registers.
// TESTING (SCAN_COUNT=4)
//  1 rst=1 for 3 cycles -> com=1111, data=FF. Release -> next cycle com=1110, data=C0.
//    Each digit then held for 4 cycles, rotating 1110,1101,1011,0111,1110.
//  2 mode0, sec=12, msec=34, after one frame boundary -> d0=99, d1=B0, d2=24 (dp lit), d3=F9.
//  3 mode0, sec=12, msec=75 -> d2=A4 (dp off). Step msec 49->50 across frames -> dp toggles at the frame boundary only.
//  4 mode1, hour=23, min=59, msec=10 -> d0=90, d1=92, d2=30, d3=A4.
//    Toggle sw_mode while d1 is shown -> d2/d3 keep the old mode until the next d0.
//  5 mode0, msec=120 -> d1 blank (FF), d0=C0. hour=31 in mode1 -> d3 decodes 3 (B0), d2 decodes 1 (F9/79 per dp).
//  6 assert rst for 1 cycle while d2 is shown -> com=1111/data=FF that cycle.
//    Then com=1110, data=C0, and a full 4-cycle dwell restarts.

Source files
------------

// File: rtl/fnd_time_display_pkg.sv
// Shared constants and helpers for the 4-digit common-anode time display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package fnd_time_display_pkg;

  localparam logic [7:0] SEG_0      = 8'hC0;
  localparam logic [7:0] SEG_1      = 8'hF9;
  localparam logic [7:0] SEG_2      = 8'hA4;
  localparam logic [7:0] SEG_3      = 8'hB0;
  localparam logic [7:0] SEG_4      = 8'h99;
  localparam logic [7:0] SEG_5      = 8'h92;
  localparam logic [7:0] SEG_6      = 8'h82;
  localparam logic [7:0] SEG_7      = 8'hF8;
  localparam logic [7:0] SEG_8      = 8'h80;
  localparam logic [7:0] SEG_9      = 8'h90;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] DP_ON_MASK = 8'h7F;

  localparam int         NUM_DIGITS     = 4;
  localparam logic [6:0] DP_BLINK_LIMIT = 7'd50;

  typedef enum logic {
    MODE_SEC_MSEC = 1'b0,
    MODE_HOUR_MIN = 1'b1
  } mode_e;

  // x*205/2048 equals x/10 exactly for every 7-bit x.
  function automatic logic [3:0] div10(input logic [6:0] x);
    return 4'(({8'd0, x} * 15'd205) >> 11);
  endfunction

  function automatic logic [3:0] mod10(input logic [6:0] x, input logic [3:0] q);
    return 4'(x - 7'({3'd0, q} * 7'd10));
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational digit-to-segment decoder, active-low outputs.
// Values above 9 blank the digit; dp_on lights the decimal point.
module fnd_seg_decoder
  import fnd_time_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp_on,
  output logic [7:0] seg
);

  logic [7:0] code_s;

  // Digit lookup with blanking for anything out of range.
  always_comb begin
    code_s = SEG_BLANK;
    case (digit)
      4'd0:    code_s = SEG_0;
      4'd1:    code_s = SEG_1;
      4'd2:    code_s = SEG_2;
      4'd3:    code_s = SEG_3;
      4'd4:    code_s = SEG_4;
      4'd5:    code_s = SEG_5;
      4'd6:    code_s = SEG_6;
      4'd7:    code_s = SEG_7;
      4'd8:    code_s = SEG_8;
      4'd9:    code_s = SEG_9;
      default: code_s = SEG_BLANK;
    endcase
  end

  // Decimal point overlay.
  always_comb begin
    seg = code_s;
    if (dp_on) begin
      seg = code_s & DP_ON_MASK;
    end else begin
      seg = code_s;
    end
  end

endmodule

// File: rtl/fnd_time_display.sv
// Multiplexed 4-digit time display: snapshots the time buses once per frame
// and scans digits right to left with registered, glitch-aligned COM/segments.
module fnd_time_display
  import fnd_time_display_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       sw_mode,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_COUNT - 1);

  logic [CNT_W-1:0] scan_cnt_r;
  logic [1:0]       dig_idx_r;
  logic [6:0]       snap_msec_r;
  logic [5:0]       snap_sec_r;
  logic [5:0]       snap_min_r;
  logic [4:0]       snap_hour_r;
  mode_e            snap_mode_r;

  logic       scan_tick_s;
  logic       frame_end_s;
  logic [6:0] lo_s;
  logic [6:0] hi_s;
  logic [3:0] lo_tens_s;
  logic [3:0] hi_tens_s;
  logic [3:0] digit_s;
  logic       dp_on_s;
  logic [7:0] seg_s;

  assign scan_tick_s = (scan_cnt_r == CNT_LAST);
  assign frame_end_s = scan_tick_s && (dig_idx_r == 2'(NUM_DIGITS - 1));

  // Digit dwell counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      dig_idx_r  <= 2'd0;
    end else if (scan_tick_s) begin
      scan_cnt_r <= '0;
      dig_idx_r  <= dig_idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + CNT_W'(1);
    end
  end

  // Frame snapshot, taken as the scan wraps back to digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_msec_r <= 7'd0;
      snap_sec_r  <= 6'd0;
      snap_min_r  <= 6'd0;
      snap_hour_r <= 5'd0;
      snap_mode_r <= MODE_SEC_MSEC;
    end else if (frame_end_s) begin
      snap_msec_r <= msec;
      snap_sec_r  <= sec;
      snap_min_r  <= min;
      snap_hour_r <= hour;
      snap_mode_r <= mode_e'(sw_mode);
    end
  end

  // Field select for the low and high digit pairs.
  always_comb begin
    lo_s = snap_msec_r;
    hi_s = {1'b0, snap_sec_r};
    if (snap_mode_r == MODE_HOUR_MIN) begin
      lo_s = {1'b0, snap_min_r};
      hi_s = {2'b00, snap_hour_r};
    end else begin
      lo_s = snap_msec_r;
      hi_s = {1'b0, snap_sec_r};
    end
  end

  assign lo_tens_s = div10(lo_s);
  assign hi_tens_s = div10(hi_s);

  // Pick the digit being scanned.
  always_comb begin
    digit_s = 4'd0;
    case (dig_idx_r)
      2'd0:    digit_s = mod10(lo_s, lo_tens_s);
      2'd1:    digit_s = lo_tens_s;
      2'd2:    digit_s = mod10(hi_s, hi_tens_s);
      2'd3:    digit_s = hi_tens_s;
      default: digit_s = 4'd0;
    endcase
  end

  assign dp_on_s = (dig_idx_r == 2'd2) && (snap_msec_r < DP_BLINK_LIMIT);

  fnd_seg_decoder u_seg_decoder (
    .digit (digit_s),
    .dp_on (dp_on_s),
    .seg   (seg_s)
  );

  // COM and segments share one register stage so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= ~(4'b0001 << dig_idx_r);
      fnd_data <= seg_s;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// Self-checking bench for fnd_time_display with SCAN_COUNT=4 (16-cycle frames).
// Table vectors plus hand sequences for mid-frame changes and reset.
module tb_fnd_time_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sw_mode;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  fnd_time_display #(.SCAN_COUNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .sw_mode  (sw_mode),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      msec;
    logic [5:0]      sec;
    logic [5:0]      min;
    logic [4:0]      hour;
    logic            mode;
    logic [3:0][7:0] exp;   // exp[0] = rightmost digit
  } vec_t;

  typedef struct {
    logic [3:0] com;
    logic [7:0] data;
  } out_t;

  vec_t vecs[10];
  out_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   k      = 0;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic cmp(input string name, input logic [3:0] ecom, input logic [7:0] edata);
    n_vec++;
    if (fnd_com !== ecom || fnd_data !== edata) begin
      n_miss++;
      $display("FAIL %s (k=%0d): got com=%b data=%h, expected com=%b data=%h",
               name, k, fnd_com, fnd_data, ecom, edata);
    end
  endtask

  task automatic drive(input logic [6:0] m, input logic [5:0] s, input logic [5:0] mi,
                       input logic [4:0] h, input logic md);
    msec = m; sec = s; min = mi; hour = h; sw_mode = md;
  endtask

  // Check one full frame; optionally change msec/sec/mode after chg_at cycles.
  task automatic check_frame(input string name, input logic [3:0][7:0] exp, input int chg_at,
                             input logic [6:0] nmsec, input logic [5:0] nsec, input logic nmode);
    out_t e;
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 4; r++) begin
        e.com  = 4'b1111 ^ (4'b0001 << j);
        e.data = exp[j];
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) begin
        msec = nmsec; sec = nsec; sw_mode = nmode;
      end
      step();
      e = sb.pop_front();
      cmp(name, e.com, e.data);
    end
  endtask

  task automatic apply_vec(input int idx);
    drive(vecs[idx].msec, vecs[idx].sec, vecs[idx].min, vecs[idx].hour, vecs[idx].mode);
    step();
    for (int g = 0; g < 16 && (k % 16) != 0; g++) step();
    check_frame($sformatf("vec%0d", idx), vecs[idx].exp, -1, 7'd0, 6'd0, 1'b0);
  endtask

  localparam logic [3:0][7:0] ZERO_FRAME = {8'hC0, 8'h40, 8'hC0, 8'hC0};

  initial begin
    vecs[0] = '{7'd34,  6'd12, 6'd0,  5'd0,  1'b0, {8'hF9, 8'h24, 8'hB0, 8'h99}};
    vecs[1] = '{7'd75,  6'd12, 6'd0,  5'd0,  1'b0, {8'hF9, 8'hA4, 8'hF8, 8'h92}};
    vecs[2] = '{7'd49,  6'd12, 6'd0,  5'd0,  1'b0, {8'hF9, 8'h24, 8'h99, 8'h90}};
    vecs[3] = '{7'd50,  6'd12, 6'd0,  5'd0,  1'b0, {8'hF9, 8'hA4, 8'h92, 8'hC0}};
    vecs[4] = '{7'd10,  6'd0,  6'd59, 5'd23, 1'b1, {8'hA4, 8'h30, 8'h92, 8'h90}};
    vecs[5] = '{7'd120, 6'd12, 6'd0,  5'd0,  1'b0, {8'hF9, 8'hA4, 8'hFF, 8'hC0}};
    vecs[6] = '{7'd120, 6'd0,  6'd59, 5'd31, 1'b1, {8'hB0, 8'hF9, 8'h92, 8'h90}};
    vecs[7] = '{7'd10,  6'd0,  6'd59, 5'd31, 1'b1, {8'hB0, 8'h79, 8'h92, 8'h90}};
    vecs[8] = '{7'd99,  6'd59, 6'd0,  5'd0,  1'b0, {8'h92, 8'h90, 8'h90, 8'h90}};
    vecs[9] = '{7'd0,   6'd0,  6'd0,  5'd0,  1'b1, {8'hC0, 8'h40, 8'hC0, 8'hC0}};

    rst = 1'b1;
    drive(7'd0, 6'd0, 6'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("reset_hold", 4'b1111, 8'hFF);
    end
    rst = 1'b0;
    k = 0;
    check_frame("first_frame", ZERO_FRAME, -1, 7'd0, 6'd0, 1'b0);

    for (int i = 0; i < 10; i++) apply_vec(i);

    // Mode flip while digit 1 is shown: frame stays HH.MM, next frame is SS.cc.
    apply_vec(4);
    check_frame("mode_hold", vecs[4].exp, 6, 7'd10, 6'd12, 1'b0);
    check_frame("mode_new", {8'hF9, 8'h24, 8'hF9, 8'hC0}, -1, 7'd0, 6'd0, 1'b0);

    // msec 49->50 during digit 2: dp stays lit until the frame boundary.
    apply_vec(2);
    check_frame("dp_hold", vecs[2].exp, 10, 7'd50, 6'd12, 1'b0);
    check_frame("dp_new", vecs[3].exp, -1, 7'd0, 6'd0, 1'b0);

    // One-cycle reset while digit 2 is shown.
    for (int g = 0; g < 16 && (k % 16) != 9; g++) step();
    rst = 1'b1;
    step();
    cmp("mid_reset", 4'b1111, 8'hFF);
    rst = 1'b0;
    k = 0;
    check_frame("post_reset", ZERO_FRAME, -1, 7'd0, 6'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
